// File: rtl/chien_search_unit_if.sv
// Handshake and result bundle for the Chien search engine.
// The requester (master) drives START/LAMBDA; the engine (slave) drives status and results.
interface chien_search_unit_if #(
   parameter int M = 4,
   parameter int T = 2
);
   logic                   START;
   logic [(T+1)*M-1:0]     LAMBDA;
   logic                   BUSY;
   logic                   LOC_VALID;
   logic                   ERR_FLAG;
   logic [M-1:0]           ERR_POS;
   logic                   DONE;
   logic [M-1:0]           ROOT_COUNT;
   logic                   FAIL;

   modport master (
      output START, LAMBDA,
      input  BUSY, LOC_VALID, ERR_FLAG, ERR_POS, DONE, ROOT_COUNT, FAIL
   );

   modport slave (
      input  START, LAMBDA,
      output BUSY, LOC_VALID, ERR_FLAG, ERR_POS, DONE, ROOT_COUNT, FAIL
   );
endinterface

// File: rtl/chien_search_unit.sv
// Chien search engine: evaluates the error-locator polynomial at alpha^i for
// i = 0..N-1 over GF(2^M), one position per clock, and reports each root as an
// error flag with its codeword position. At the end of the sweep the root count
// is compared with the locator degree to detect an uncorrectable codeword.
module chien_search_unit #(
   parameter int         M         = 4,
   parameter int         T         = 2,
   parameter int         N         = 15,
   parameter logic [M:0] PRIM_POLY = 5'b10011
) (
   input logic                CLK,
   input logic                RESET,
   chien_search_unit_if.slave bus
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SWEEP = 1'b1
   } state_t;

   localparam logic [M-1:0] ZERO_M   = {M{1'b0}};
   localparam logic [M-1:0] ONE_M    = M'(1);
   localparam logic [M-1:0] N_M      = M'(N);
   localparam logic [M-1:0] LAST_IDX = M'(N - 1);

   // Multiply a field element by alpha: shift left, reduce by the field polynomial.
   function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
      logic [M-1:0] s;
      s = {a[M-2:0], 1'b0};
      if (a[M-1]) begin
         s = s ^ PRIM_POLY[M-1:0];
      end else begin
         s = s;
      end
      return s;
   endfunction

   // Multiply by alpha^j as j chained xtime steps; j is always an elaboration constant.
   function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] a, input int j);
      logic [M-1:0] s;
      s = a;
      for (int k = 0; k < T; k++) begin
         if (k < j) begin
            s = xtime(s);
         end else begin
            s = s;
         end
      end
      return s;
   endfunction

   state_t       state_q, state_d;
   logic [M-1:0] r_q [0:T];
   logic [M-1:0] r_d [0:T];
   logic [M-1:0] idx_q, idx_d;
   logic [M-1:0] cnt_q, cnt_d;
   logic [M-1:0] deg_q, deg_d;
   logic         lam0_zero_q, lam0_zero_d;
   logic         busy_q, busy_d;
   logic         loc_valid_q, loc_valid_d;
   logic         err_flag_q, err_flag_d;
   logic [M-1:0] err_pos_q, err_pos_d;
   logic         done_q, done_d;
   logic [M-1:0] root_count_q, root_count_d;
   logic         fail_q, fail_d;

   logic [M-1:0] lam_s [0:T];
   logic [M-1:0] deg_s;
   logic [M-1:0] syn_s;
   logic [M-1:0] cnt_next_s;

   // Unpack the locator coefficients and find the degree of the incoming polynomial.
   always_comb begin
      deg_s = ZERO_M;
      for (int j = 0; j <= T; j++) begin
         lam_s[j] = bus.LAMBDA[j*M +: M];
      end
      for (int j = 1; j <= T; j++) begin
         if (lam_s[j] != ZERO_M) begin
            deg_s = M'(j);
         end else begin
            deg_s = deg_s;
         end
      end
   end

   // Lambda(alpha^idx) is the XOR of all term registers; a zero sum marks a root.
   always_comb begin
      syn_s = ZERO_M;
      for (int j = 0; j <= T; j++) begin
         syn_s = syn_s ^ r_q[j];
      end
      cnt_next_s = cnt_q + ((syn_s == ZERO_M) ? ONE_M : ZERO_M);
   end

   // Next-state and output logic for the IDLE/SWEEP controller.
   always_comb begin
      state_d      = state_q;
      for (int j = 0; j <= T; j++) begin
         r_d[j] = r_q[j];
      end
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      deg_d        = deg_q;
      lam0_zero_d  = lam0_zero_q;
      busy_d       = busy_q;
      loc_valid_d  = 1'b0;
      err_flag_d   = err_flag_q;
      err_pos_d    = err_pos_q;
      done_d       = 1'b0;
      root_count_d = root_count_q;
      fail_d       = fail_q;

      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               for (int j = 0; j <= T; j++) begin
                  r_d[j] = lam_s[j];
               end
               idx_d       = ZERO_M;
               cnt_d       = ZERO_M;
               deg_d       = deg_s;
               lam0_zero_d = (lam_s[0] == ZERO_M);
               busy_d      = 1'b1;
               state_d     = S_SWEEP;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_SWEEP: begin
            loc_valid_d = 1'b1;
            err_flag_d  = (syn_s == ZERO_M);
            // Position is the inverse exponent: alpha^i is a root for the symbol at N-i.
            err_pos_d   = (idx_q == ZERO_M) ? ZERO_M : (N_M - idx_q);
            for (int j = 0; j <= T; j++) begin
               r_d[j] = mul_alpha_pow(r_q[j], j);
            end
            if (idx_q == LAST_IDX) begin
               idx_d        = ZERO_M;
               cnt_d        = cnt_next_s;
               root_count_d = cnt_next_s;
               fail_d       = lam0_zero_q | (cnt_next_s != deg_q);
               done_d       = 1'b1;
               busy_d       = 1'b0;
               state_d      = S_IDLE;
            end else begin
               idx_d   = idx_q + ONE_M;
               cnt_d   = cnt_next_s;
               busy_d  = 1'b1;
               state_d = S_SWEEP;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         for (int j = 0; j <= T; j++) begin
            r_q[j] <= ZERO_M;
         end
         idx_q        <= ZERO_M;
         cnt_q        <= ZERO_M;
         deg_q        <= ZERO_M;
         lam0_zero_q  <= 1'b0;
         busy_q       <= 1'b0;
         loc_valid_q  <= 1'b0;
         err_flag_q   <= 1'b0;
         err_pos_q    <= ZERO_M;
         done_q       <= 1'b0;
         root_count_q <= ZERO_M;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         for (int j = 0; j <= T; j++) begin
            r_q[j] <= r_d[j];
         end
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         deg_q        <= deg_d;
         lam0_zero_q  <= lam0_zero_d;
         busy_q       <= busy_d;
         loc_valid_q  <= loc_valid_d;
         err_flag_q   <= err_flag_d;
         err_pos_q    <= err_pos_d;
         done_q       <= done_d;
         root_count_q <= root_count_d;
         fail_q       <= fail_d;
      end
   end

   assign bus.BUSY       = busy_q;
   assign bus.LOC_VALID  = loc_valid_q;
   assign bus.ERR_FLAG   = err_flag_q;
   assign bus.ERR_POS    = err_pos_q;
   assign bus.DONE       = done_q;
   assign bus.ROOT_COUNT = root_count_q;
   assign bus.FAIL       = fail_q;

endmodule

// File: tb/tb_chien_search_unit.sv
// Self-checking bench for chien_search_unit (M=4, T=2, N=15, x^4+x+1).
// Reference: direct polynomial evaluation of Lambda(alpha^i) with a
// shift-and-add GF(16) multiplier.
module tb_chien_search_unit;
   localparam int M = 4;
   localparam int T = 2;
   localparam int N = 15;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   logic [M-1:0] exp_rc;
   logic         exp_fail;
   logic [15:0]  flag_mask;

   chien_search_unit_if #(.M(M), .T(T)) bus ();

   chien_search_unit #(.M(M), .T(T), .N(N), .PRIM_POLY(5'b10011)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int k = 0; k < 4; k++) if (b[k]) p = p ^ (8'(a) << k);
      for (int k = 7; k >= 4; k--) if (p[k]) p = p ^ (8'h13 << (k - 4));
      return p[3:0];
   endfunction

   function automatic logic [3:0] alpha_pow(input int e);
      logic [3:0] x;
      x = 4'h1;
      for (int k = 0; k < (e % N); k++) x = gf_mul(x, 4'h2);
      return x;
   endfunction

   function automatic logic [3:0] eval_lambda(input logic [11:0] lam, input int i);
      logic [3:0] x, xp, sum;
      x = alpha_pow(i);
      xp = 4'h1;
      sum = 4'h0;
      for (int j = 0; j <= T; j++) begin
         sum = sum ^ gf_mul(lam[j*M +: M], xp);
         xp = gf_mul(xp, x);
      end
      return sum;
   endfunction

   task automatic test_reset();
      checks++;
      if (bus.BUSY !== 1'b0 || bus.LOC_VALID !== 1'b0 || bus.ERR_FLAG !== 1'b0 ||
          bus.ERR_POS !== 4'd0 || bus.DONE !== 1'b0 || bus.ROOT_COUNT !== 4'd0 || bus.FAIL !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b lv=%b flag=%b pos=%0d done=%b rc=%0d fail=%b, required all zero",
                  bus.BUSY, bus.LOC_VALID, bus.ERR_FLAG, bus.ERR_POS, bus.DONE, bus.ROOT_COUNT, bus.FAIL);
      end
   endtask

   // Called at a negedge; leaves us at the negedge after the accepting edge.
   task automatic start_pulse(input logic [11:0] lam);
      bus.START = 1'b1;
      bus.LAMBDA = lam;
      @(negedge clk);
      bus.START = 1'b0;
      checks++;
      if (bus.BUSY !== 1'b1 || bus.LOC_VALID !== 1'b0 || bus.DONE !== 1'b0) begin
         errors++;
         $display("FAIL start_accept: busy=%b lv=%b done=%b, required busy=1 lv=0 done=0",
                  bus.BUSY, bus.LOC_VALID, bus.DONE);
      end
   endtask

   task automatic check_sweep(input logic [11:0] lam, input bit restart_mid);
      int cnt, deg;
      logic ef;
      logic [3:0] ep;
      cnt = 0;
      deg = 0;
      flag_mask = 16'h0000;
      for (int j = 1; j <= T; j++) if (lam[j*M +: M] != 4'h0) deg = j;
      for (int c = 0; c < N; c++) begin
         if (restart_mid && c == 5) begin
            bus.START = 1'b1;
            bus.LAMBDA = lam ^ 12'h5A5;
         end else begin
            bus.START = 1'b0;
         end
         @(negedge clk);
         ef = (eval_lambda(lam, c) == 4'h0);
         if (ef) cnt++;
         ep = 4'((N - c) % N);
         if (bus.LOC_VALID === 1'b1 && bus.ERR_FLAG === 1'b1) flag_mask[bus.ERR_POS] = 1'b1;
         checks++;
         if (bus.LOC_VALID !== 1'b1 || bus.ERR_FLAG !== ef || bus.ERR_POS !== ep) begin
            errors++;
            $display("FAIL sweep_pos lam=%h i=%0d: lv=%b flag=%b pos=%0d, required lv=1 flag=%b pos=%0d",
                     lam, c, bus.LOC_VALID, bus.ERR_FLAG, bus.ERR_POS, ef, ep);
         end
         checks++;
         if (bus.DONE !== (c == N - 1) || bus.BUSY !== (c != N - 1)) begin
            errors++;
            $display("FAIL sweep_ctrl lam=%h i=%0d: done=%b busy=%b, required done=%b busy=%b",
                     lam, c, bus.DONE, bus.BUSY, (c == N - 1), (c != N - 1));
         end
         if (c == N - 1) begin
            exp_rc = 4'(cnt);
            exp_fail = (lam[3:0] == 4'h0) || (cnt != deg);
         end
         checks++;
         if (bus.ROOT_COUNT !== exp_rc || bus.FAIL !== exp_fail) begin
            errors++;
            $display("FAIL sweep_result lam=%h i=%0d: rc=%0d fail=%b, required rc=%0d fail=%b",
                     lam, c, bus.ROOT_COUNT, bus.FAIL, exp_rc, exp_fail);
         end
      end
      bus.START = 1'b0;
   endtask

   task automatic check_known(input string name, input logic [15:0] mask, input logic [3:0] rc, input logic fl);
      checks++;
      if (flag_mask !== mask || bus.ROOT_COUNT !== rc || bus.FAIL !== fl) begin
         errors++;
         $display("FAIL %s: mask=%h rc=%0d fail=%b, required mask=%h rc=%0d fail=%b",
                  name, flag_mask, bus.ROOT_COUNT, bus.FAIL, mask, rc, fl);
      end
   endtask

   task automatic test_known_vectors();
      start_pulse(12'h081); check_sweep(12'h081, 1'b0);
      check_known("single_error", 16'h0008, 4'd1, 1'b0);
      @(negedge clk);
      start_pulse(12'hC41); check_sweep(12'hC41, 1'b0);
      check_known("two_errors", 16'h0022, 4'd2, 1'b0);
      @(negedge clk);
      start_pulse(12'h201); check_sweep(12'h201, 1'b0);
      check_known("uncorrectable", 16'h0100, 4'd1, 1'b1);
      @(negedge clk);
      start_pulse(12'h001); check_sweep(12'h001, 1'b0);
      check_known("no_error", 16'h0000, 4'd0, 1'b0);
      @(negedge clk);
      start_pulse(12'h040); check_sweep(12'h040, 1'b0);
      check_known("lambda0_zero", 16'h0000, 4'd0, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_restart_ignored();
      start_pulse(12'hC41);
      check_sweep(12'hC41, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      start_pulse(12'h081);
      check_sweep(12'h081, 1'b0);
      start_pulse(12'h201);
      check_sweep(12'h201, 1'b0);
      start_pulse(12'hC41);
      check_sweep(12'hC41, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_sweep();
      start_pulse(12'hC41);
      for (int c = 0; c < 6; c++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      rst = 1'b0;
      exp_rc = 4'd0;
      exp_fail = 1'b0;
      for (int k = 0; k < N + 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.DONE !== 1'b0 || bus.LOC_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL after_reset cyc=%0d: done=%b lv=%b busy=%b, required all 0",
                     k, bus.DONE, bus.LOC_VALID, bus.BUSY);
         end
      end
      start_pulse(12'h081);
      check_sweep(12'h081, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [11:0] lam;
      int a, b;
      for (int n = 0; n < 12; n++) begin
         if (n % 2 == 0) begin
            a = int'($urandom_range(0, N - 1));
            b = int'($urandom_range(0, N - 1));
            lam = {gf_mul(alpha_pow(a), alpha_pow(b)), alpha_pow(a) ^ alpha_pow(b), 4'h1};
         end else begin
            lam = 12'($urandom);
         end
         start_pulse(lam);
         check_sweep(lam, n == 3);
         if (n % 3 == 0) @(negedge clk);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bus.START = 1'b0;
      bus.LAMBDA = 12'h000;
      exp_rc = 4'd0;
      exp_fail = 1'b0;
      flag_mask = 16'h0000;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_known_vectors();
      test_restart_ignored();
      test_back_to_back();
      test_reset_mid_sweep();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/chien_search_unit.md
# chien_search_unit

Parametrised Chien search engine for the Reed-Solomon decoder's error-location stage. It takes the error-locator polynomial Λ(x) from the key-equation solver, evaluates Λ(α^i) for every i = 0..N−1 over GF(2^M), and streams one error/no-error flag per codeword position. When the sweep ends it reports the root count and a decoding-failure flag. It generalises the single-coefficient multiply-by-α Chien cell to T+1 coefficient registers, arbitrary field width and a start/busy/done handshake.

## Interface
- M, default 4: symbol width in bits; field GF(2^M).
- T, default 2: maximum locator degree, equal to the correctable symbol count.
- N, default 15: positions swept. Must equal 2^M−1.
- PRIM_POLY, default 5'b10011: field polynomial, M+1 bits (x^4+x+1).
- CLK  input  1  rising-edge clock; the only clock.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request; loads LAMBDA. Ignored while BUSY=1.
- LAMBDA  input  (T+1)*M  locator coefficients. Λ_j occupies bits [j*M+M−1 : j*M]; Λ_0 is in the LSBs.
- BUSY  output  1  sweep in progress.
- LOC_VALID  output  1  ERR_FLAG and ERR_POS are valid this cycle.
- ERR_FLAG  output  1  Λ(α^i) = 0, so the symbol at ERR_POS is in error.
- ERR_POS  output  M  codeword position, equal to (N−i) mod N.
- DONE  output  1  one-cycle pulse that marks the end of a sweep.
- ROOT_COUNT  output  M  number of roots found. Valid while DONE=1 and held afterwards.
- FAIL  output  1  decoding failure. Valid while DONE=1 and held afterwards.

## Operation
- Registers: r_0..r_T, each M bits; index counter idx; root counter; degree register deg.
- Accepted START:
  - r_j ← Λ_j and idx ← 0.
  - deg ← index of the highest nonzero Λ_j; deg = 0 if all are zero.
  - lam0_zero ← (Λ_0 == 0).
  - Root counter is cleared.
- Each BUSY cycle:
  - S = XOR of all r_j.
  - Registered outputs: ERR_FLAG ← (S == 0), ERR_POS ← (N−idx) mod N, LOC_VALID ← 1.
  - Root counter increments when S == 0.
  - r_j ← r_j · α^j. The r_0 multiplier is the identity.
  - idx ← idx+1.
- The constant multiply by α^j is j repeated xtime steps reduced by PRIM_POLY. It is purely combinational and needs no lookup ROM.
- Arithmetic: all field addition is XOR. idx and ERR_POS wrap modulo N, with i = 0 mapping to position 0.
- End of sweep: when idx = N−1 is processed, BUSY ← 0 and DONE ← 1.
  - ROOT_COUNT is the final count, including the last position.
  - FAIL = lam0_zero OR (ROOT_COUNT ≠ deg).
- States: IDLE (BUSY=0) → SWEEP (BUSY=1, N cycles) → IDLE. DONE is asserted on the transition back to IDLE.
- START while BUSY=1 is ignored and does not disturb the sweep.
- START during the cycle in which DONE=1 is accepted, because BUSY is already 0.
- RESET has priority over everything, including a mid-sweep request. It returns to IDLE with no DONE pulse.
- Reset values: BUSY=0, LOC_VALID=0, ERR_FLAG=0, ERR_POS=0, DONE=0, ROOT_COUNT=0, FAIL=0, all r_j=0, idx=0.

## Timing
- START is sampled at edge k.
- BUSY is 1 in the cycles following edges k through k+N−1.
- LOC_VALID is 1 in the N cycles following edges k+1 through k+N. The first valid cycle carries i=0; the last carries i=N−1.
- DONE is 1 for exactly one cycle, coincident with the last LOC_VALID. BUSY is 0 in that cycle.
- Back-to-back throughput is one sweep per N+1 cycles. LOC_VALID has a one-cycle gap between sweeps.
- ERR_FLAG and ERR_POS hold their last value when LOC_VALID=0. Only LOC_VALID qualifies them.
- ROOT_COUNT and FAIL change only in the DONE cycle or on RESET.

## Test plan
All cases use M=4, T=2, α=2, x^4+x+1.
- Single error: LAMBDA={1,8,0} → exactly one ERR_FLAG, at i=12 with ERR_POS=3; ROOT_COUNT=1; FAIL=0; DONE after 15 valid cycles.
- Two errors: LAMBDA={1,4,12} → flags at ERR_POS=1 (i=14) and ERR_POS=5 (i=10); ROOT_COUNT=2; FAIL=0.
- Uncorrectable: LAMBDA={1,0,2} → one flag at ERR_POS=8 (i=7); ROOT_COUNT=1; deg=2; FAIL=1.
- No error, then Λ_0=0:
  - LAMBDA={1,0,0} → no flags; ROOT_COUNT=0; FAIL=0.
  - Then {0,4,0} → no flags; FAIL=1.
- Handshake:
  - START pulsed again mid-sweep → ignored; exactly 15 LOC_VALID cycles.
  - START in the DONE cycle → the next sweep's first LOC_VALID follows exactly one idle cycle.
- Reset mid-sweep: RESET at i=6 → next cycle all outputs are at reset values and no DONE follows. A new START then produces a full, correct sweep.
